// File: rtl/bus_transceiver_seq.sv
// Clocked bidirectional bus transceiver: local d_in/d_out pair to a shared
// tri-state bus, with registered paths and a guaranteed turnaround dead time.
module bus_transceiver_seq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned INVERTED_OUTPUT = 0,
    parameter int unsigned TURN_CYCLES     = 2,
    parameter int unsigned HOLD_OUTPUT     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_out_valid,
    inout  wire  [WIDTH-1:0] d_bus,
    input  logic             cs_n,
    input  logic             dce,
    output logic             bus_drive,
    output logic             busy
);

    localparam int unsigned CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] d_out_d;
    logic             d_out_valid_d;
    logic             bus_drive_d;
    logic             busy_d;
    logic             rd_c;
    logic             wr_c;
    logic [WIDTH-1:0] bus_in_c;
    logic [WIDTH-1:0] bus_out_c;

    // Request decode and data polarity in both directions
    assign rd_c      = !cs_n && !dce;
    assign wr_c      = !cs_n && dce;
    assign bus_in_c  = (INVERTED_OUTPUT != 0) ? ~d_bus : d_bus;
    assign bus_out_c = (INVERTED_OUTPUT != 0) ? ~data_q : data_q;

    // Bus is driven only from registered enable and data
    assign d_bus = bus_drive ? bus_out_c : {WIDTH{1'bz}};

    // Next-state, counter, data and output-register logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        d_out_d       = d_out;
        d_out_valid_d = d_out_valid;

        case (state_q)
            IDLE: begin
                if (rd_c) begin
                    state_d = READ;
                    data_d  = d_in;
                end else if (wr_c) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (rd_c) begin
                    data_d = d_in;
                end else begin
                    state_d = TURN;
                    cnt_d   = CNT_LOAD;
                end
            end
            WRITE: begin
                d_out_d       = bus_in_c;
                d_out_valid_d = 1'b1;
                if (rd_c) begin
                    state_d = TURN;
                    cnt_d   = CNT_LOAD;
                end else if (!wr_c) begin
                    state_d = IDLE;
                end
                if ((state_d != WRITE) && (HOLD_OUTPUT == 0)) begin
                    d_out_d       = '0;
                    d_out_valid_d = 1'b0;
                end
            end
            TURN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rd_c) begin
                    state_d = READ;
                    data_d  = d_in;
                end else if (wr_c) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        bus_drive_d = (state_d == READ);
        busy_d      = (state_d == TURN);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            d_out       <= '0;
            d_out_valid <= 1'b0;
            bus_drive   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            d_out       <= d_out_d;
            d_out_valid <= d_out_valid_d;
            bus_drive   <= bus_drive_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_transceiver_seq.sv
// Bench for bus_transceiver_seq: two instances (inverting/holding and
// non-inverting/clearing) share control inputs; each has its own bus with a
// different pull so a released bus reads back as a known value.
module tb_bus_transceiver_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned TC = 2;
    localparam logic [W-1:0] PA = 4'b1111;  // released level of bus_a
    localparam logic [W-1:0] PB = 4'b0000;  // released level of bus_b

    localparam int M_IDLE  = 0;
    localparam int M_READ  = 1;
    localparam int M_WRITE = 2;
    localparam int M_TURN  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] d_in;
    logic         cs_n;
    logic         dce;
    logic         drv_en;
    logic [W-1:0] drv_val;

    wire  [W-1:0] bus_a;
    wire  [W-1:0] bus_b;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         val_a;
    logic         val_b;
    logic         drive_a;
    logic         drive_b;
    logic         busy_a;
    logic         busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign bus_a = drv_en ? drv_val : {W{1'bz}};
    assign bus_b = drv_en ? drv_val : {W{1'bz}};

    for (genvar g = 0; g < W; g++) begin : g_pull
        pullup   (bus_a[g]);
        pulldown (bus_b[g]);
    end

    bus_transceiver_seq #(
        .WIDTH(W), .INVERTED_OUTPUT(1), .TURN_CYCLES(TC), .HOLD_OUTPUT(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_out(out_a),
        .d_out_valid(val_a), .d_bus(bus_a), .cs_n(cs_n), .dce(dce),
        .bus_drive(drive_a), .busy(busy_a)
    );

    bus_transceiver_seq #(
        .WIDTH(W), .INVERTED_OUTPUT(0), .TURN_CYCLES(TC), .HOLD_OUTPUT(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_out(out_b),
        .d_out_valid(val_b), .d_bus(bus_b), .cs_n(cs_n), .dce(dce),
        .bus_drive(drive_b), .busy(busy_b)
    );

    typedef struct {
        logic         rst_n;
        logic         cs_n;
        logic         dce;
        logic [W-1:0] d_in;
        logic         drv_en;
        logic [W-1:0] drv_val;
        logic         e_drive;
        logic         e_busy;
        logic [W-1:0] e_out_a;
        logic         e_val_a;
        logic [W-1:0] e_out_b;
        logic         e_val_b;
        logic [W-1:0] e_bus_a;
        logic [W-1:0] e_bus_b;
    } vec_t;

    typedef struct {
        int           mode;
        int           left;
        logic [W-1:0] data;
        logic [W-1:0] dout;
        logic         valid;
    } mdl_t;

    vec_t vecs[28];
    mdl_t ma;
    mdl_t mb;

    function automatic vec_t mk(logic r, logic c, logic d, logic [W-1:0] di,
                                logic de, logic [W-1:0] dv, logic edr, logic eby,
                                logic [W-1:0] eao, logic eav, logic [W-1:0] ebo,
                                logic ebv, logic [W-1:0] eba, logic [W-1:0] ebb);
        vec_t v;
        v.rst_n = r;    v.cs_n = c;      v.dce = d;       v.d_in = di;
        v.drv_en = de;  v.drv_val = dv;  v.e_drive = edr; v.e_busy = eby;
        v.e_out_a = eao; v.e_val_a = eav; v.e_out_b = ebo; v.e_val_b = ebv;
        v.e_bus_a = eba; v.e_bus_b = ebb;
        return v;
    endfunction

    // Reference behaviour of one transceiver for one clock edge
    function automatic mdl_t step(mdl_t m, logic r, logic c, logic d,
                                  logic [W-1:0] din, logic [W-1:0] busv,
                                  bit inv, bit hold);
        mdl_t n;
        int   req;
        n   = m;
        req = c ? 0 : (d ? 2 : 1);
        if (!r) begin
            n.mode = M_IDLE; n.left = 0; n.data = '0; n.dout = '0; n.valid = 1'b0;
            return n;
        end
        case (m.mode)
            M_IDLE: begin
                if (req == 1) begin n.mode = M_READ; n.data = din; end
                else if (req == 2) n.mode = M_WRITE;
            end
            M_READ: begin
                if (req == 1) n.data = din;
                else begin n.mode = M_TURN; n.left = TC - 1; end
            end
            M_WRITE: begin
                n.dout  = inv ? ~busv : busv;
                n.valid = 1'b1;
                if (req != 2) begin
                    n.mode = (req == 1) ? M_TURN : M_IDLE;
                    n.left = TC - 1;
                    if (!hold) begin n.dout = '0; n.valid = 1'b0; end
                end
            end
            default: begin
                if (m.left > 0) n.left = m.left - 1;
                else begin
                    n.mode = (req == 1) ? M_READ : (req == 2) ? M_WRITE : M_IDLE;
                    if (req == 1) n.data = din;
                end
            end
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; dce = 1'b0; d_in = '0; drv_en = 1'b0; drv_val = '0;

        // Directed sequence: reset, read, read->write turn, hold/clear,
        // write->read turn, request toggling in TURN, mid-operation resets.
        vecs[0]  = mk(0,1,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[1]  = mk(0,1,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[2]  = mk(1,1,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[3]  = mk(1,0,0,4'b0101,0,4'b0000, 1,0,4'b0000,0,4'b0000,0,4'b1010,4'b0101);
        vecs[4]  = mk(1,0,0,4'b0001,0,4'b0000, 1,0,4'b0000,0,4'b0000,0,4'b1110,4'b0001);
        vecs[5]  = mk(1,0,1,4'b0001,0,4'b0000, 0,1,4'b0000,0,4'b0000,0,PA,PB);
        vecs[6]  = mk(1,0,1,4'b0001,1,4'b0100, 0,1,4'b0000,0,4'b0000,0,4'b0100,4'b0100);
        vecs[7]  = mk(1,0,1,4'b0000,1,4'b0100, 0,0,4'b0000,0,4'b0000,0,4'b0100,4'b0100);
        vecs[8]  = mk(1,0,1,4'b0000,1,4'b0100, 0,0,4'b1011,1,4'b0100,1,4'b0100,4'b0100);
        vecs[9]  = mk(1,1,0,4'b0000,1,4'b0100, 0,0,4'b1011,1,4'b0000,0,4'b0100,4'b0100);
        vecs[10] = mk(1,1,0,4'b0000,1,4'b0100, 0,0,4'b1011,1,4'b0000,0,4'b0100,4'b0100);
        vecs[11] = mk(1,0,1,4'b0000,1,4'b0110, 0,0,4'b1011,1,4'b0000,0,4'b0110,4'b0110);
        vecs[12] = mk(1,0,1,4'b0000,1,4'b0110, 0,0,4'b1001,1,4'b0110,1,4'b0110,4'b0110);
        vecs[13] = mk(1,0,0,4'b0011,1,4'b0110, 0,1,4'b1001,1,4'b0000,0,4'b0110,4'b0110);
        vecs[14] = mk(1,0,0,4'b0011,0,4'b0000, 0,1,4'b1001,1,4'b0000,0,PA,PB);
        vecs[15] = mk(1,0,0,4'b0011,0,4'b0000, 1,0,4'b1001,1,4'b0000,0,4'b1100,4'b0011);
        vecs[16] = mk(1,0,0,4'b1111,0,4'b0000, 1,0,4'b1001,1,4'b0000,0,4'b0000,4'b1111);
        vecs[17] = mk(1,0,1,4'b1111,0,4'b0000, 0,1,4'b1001,1,4'b0000,0,PA,PB);
        vecs[18] = mk(1,0,0,4'b1111,1,4'b1000, 0,1,4'b1001,1,4'b0000,0,4'b1000,4'b1000);
        vecs[19] = mk(1,0,1,4'b0000,1,4'b1000, 0,0,4'b1001,1,4'b0000,0,4'b1000,4'b1000);
        vecs[20] = mk(1,0,1,4'b0000,1,4'b1000, 0,0,4'b0111,1,4'b1000,1,4'b1000,4'b1000);
        vecs[21] = mk(1,0,0,4'b0000,1,4'b1000, 0,1,4'b0111,1,4'b0000,0,4'b1000,4'b1000);
        vecs[22] = mk(0,0,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[23] = mk(1,1,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[24] = mk(1,0,0,4'b1010,0,4'b0000, 1,0,4'b0000,0,4'b0000,0,4'b0101,4'b1010);
        vecs[25] = mk(0,0,0,4'b1010,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[26] = mk(1,1,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);
        vecs[27] = mk(1,1,0,4'b0000,0,4'b0000, 0,0,4'b0000,0,4'b0000,0,PA,PB);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; cs_n = vecs[i].cs_n; dce = vecs[i].dce;
            d_in = vecs[i].d_in; drv_en = vecs[i].drv_en; drv_val = vecs[i].drv_val;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d drive_a", i), W'(drive_a), W'(vecs[i].e_drive));
            chk($sformatf("v%0d drive_b", i), W'(drive_b), W'(vecs[i].e_drive));
            chk($sformatf("v%0d busy_a", i),  W'(busy_a),  W'(vecs[i].e_busy));
            chk($sformatf("v%0d busy_b", i),  W'(busy_b),  W'(vecs[i].e_busy));
            chk($sformatf("v%0d d_out_a", i), out_a, vecs[i].e_out_a);
            chk($sformatf("v%0d valid_a", i), W'(val_a), W'(vecs[i].e_val_a));
            chk($sformatf("v%0d d_out_b", i), out_b, vecs[i].e_out_b);
            chk($sformatf("v%0d valid_b", i), W'(val_b), W'(vecs[i].e_val_b));
            chk($sformatf("v%0d bus_a", i),   bus_a, vecs[i].e_bus_a);
            chk($sformatf("v%0d bus_b", i),   bus_b, vecs[i].e_bus_b);
        end

        // Random traffic against the reference model; both blocks sit in IDLE
        // with cleared registers after the directed sequence.
        ma.mode = M_IDLE; ma.left = 0; ma.data = '0; ma.dout = '0; ma.valid = 1'b0;
        mb = ma;
        for (int i = 0; i < 600; i++) begin
            mdl_t         probe;
            logic [W-1:0] seen_a;
            logic [W-1:0] seen_b;
            logic [W-1:0] exp_a;
            logic [W-1:0] exp_b;
            @(negedge clk);
            rst_n = ($urandom_range(0, 49) != 0);
            cs_n  = ($urandom_range(0, 3) == 0);
            dce   = 1'($urandom_range(0, 1));
            d_in  = W'($urandom_range(0, 15));
            probe = step(ma, rst_n, cs_n, dce, d_in, '0, 1'b1, 1'b1);
            // Remote side drives only while neither the current nor the next
            // cycle has the transceiver driving, so there is never contention.
            drv_en  = (ma.mode != M_READ) && (probe.mode != M_READ) &&
                      ($urandom_range(0, 7) != 0);
            drv_val = W'($urandom_range(0, 15));
            seen_a  = drv_en ? drv_val : PA;
            seen_b  = drv_en ? drv_val : PB;
            ma = step(ma, rst_n, cs_n, dce, d_in, seen_a, 1'b1, 1'b1);
            mb = step(mb, rst_n, cs_n, dce, d_in, seen_b, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            exp_a = (ma.mode == M_READ) ? ~ma.data : seen_a;
            exp_b = (mb.mode == M_READ) ?  mb.data : seen_b;
            chk($sformatf("r%0d drive_a", i), W'(drive_a), W'(ma.mode == M_READ));
            chk($sformatf("r%0d drive_b", i), W'(drive_b), W'(mb.mode == M_READ));
            chk($sformatf("r%0d busy_a", i),  W'(busy_a),  W'(ma.mode == M_TURN));
            chk($sformatf("r%0d busy_b", i),  W'(busy_b),  W'(mb.mode == M_TURN));
            chk($sformatf("r%0d d_out_a", i), out_a, ma.dout);
            chk($sformatf("r%0d valid_a", i), W'(val_a), W'(ma.valid));
            chk($sformatf("r%0d d_out_b", i), out_b, mb.dout);
            chk($sformatf("r%0d valid_b", i), W'(val_b), W'(mb.valid));
            chk($sformatf("r%0d bus_a", i),   bus_a, exp_a);
            chk($sformatf("r%0d bus_b", i),   bus_b, exp_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_transceiver_seq.md
Name: bus_transceiver_seq

Overview:
Clocked, parametrised successor to the IC82x6 bidirectional bus driver.
- Moves data between a local port pair (d_in/d_out) and a shared tri-state bus (d_bus) under cs_n/dce control, as in the ISA-to-CAMAC interface board.
- Adds registered data paths, optional inversion, a held output latch, and a guaranteed bus-turnaround dead time so that direction changes can never cause bus contention.

Parameters:
WIDTH, 4, data width of d_in, d_out and d_bus (>=1).
INVERTED_OUTPUT, 0, 1 = invert data in both directions (8226 style); 0 = non-inverting (8216 style).
TURN_CYCLES, 2, number of dead cycles with the bus released on each direction reversal (>=1).
HOLD_OUTPUT, 1, 1 = d_out keeps the last captured value after WRITE ends; 0 = d_out clears to 0.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low.
d_in  input  WIDTH  local data to be driven onto the bus.
d_out  output  WIDTH  captured bus data, always driven.
d_out_valid  output  1  d_out holds data captured since reset or since the last clear.
d_bus  inout  WIDTH  shared bus; driven only while bus_drive=1, otherwise Z.
cs_n  input  1  chip select, active-low.
dce  input  1  direction: 0 = read (d_in->d_bus), 1 = write (d_bus->d_out).
bus_drive  output  1  registered bus output enable (status).
busy  output  1  high while in the TURN state.

Behaviour:
- Requests are sampled each clk:
  - RD = !cs_n & !dce
  - WR = !cs_n & dce
  - NONE = cs_n
- Reset (rst_n=0 at an edge, including mid-operation):
  - state=IDLE, bus_drive=0 (bus released on that edge).
  - d_out=0, d_out_valid=0, busy=0, turn counter=0, data register=0.
- States:
  - IDLE: RD -> READ; WR -> WRITE; NONE -> stay. Bus released, no capture.
  - READ:
    - bus_drive=1.
    - Data register loads d_in every cycle; d_bus = INVERTED_OUTPUT ? ~reg : reg. Latency is 1 clk from d_in to d_bus.
    - RD -> stay. WR or NONE -> TURN; bus_drive drops on that same edge.
  - WRITE:
    - d_out loads (INVERTED_OUTPUT ? ~d_bus : d_bus) every cycle; d_out_valid=1 from the first capture.
    - WR -> stay. RD -> TURN. NONE -> IDLE (no dead time needed: the bus was not driven).
    - On leaving WRITE with HOLD_OUTPUT=0: d_out cleared to 0 and d_out_valid=0 on the exit edge. With HOLD_OUTPUT=1: both retained.
  - TURN:
    - bus_drive=0, busy=1, no capture.
    - Counter is loaded with TURN_CYCLES-1 on entry and decrements each cycle.
    - At counter=0 the next state follows the current request: RD -> READ, WR -> WRITE, NONE -> IDLE.
    - Request changes during TURN do not restart the count.
    - Exact duration is TURN_CYCLES clocks with busy=1.
- Bus-driving rules:
  - IDLE -> READ is direct; the bus is free when cs_n was high.
  - Every READ exit and every WRITE -> READ transition passes through TURN.
- bus_drive and d_bus are derived only from registered state; no combinational path from cs_n/dce to the bus enable.
- Z or X bits on d_bus are captured as-is; there is no filtering.

Test Plan:
1. Reset. rst_n=0 for 2 clk, then release. Required: d_bus=Z, d_out=0, d_out_valid=0, bus_drive=0, busy=0.
2. Read. INVERTED_OUTPUT=1, d_in=4'b0101, cs_n=0, dce=0 from IDLE. Required: bus_drive=1 after 1 clk; d_bus=4'b1010 one clk after d_in is stable. Change d_in to 4'b0001 -> d_bus=4'b1110 after 1 clk.
3. Read to write. TURN_CYCLES=2; in READ set dce=1 while the bench drives d_bus=4'b0100 only after bus_drive=0. Required: bus_drive=0 on the first edge; busy=1 for exactly 2 clk; then WRITE with d_out=4'b1011 and d_out_valid=1.
4. Hold. From WRITE set cs_n=1. Required with HOLD_OUTPUT=1: IDLE immediately (busy stays 0), d_out stays 4'b1011. Repeat with HOLD_OUTPUT=0: d_out=0 and d_out_valid=0 on the exit edge.
5. Write to read. In WRITE set dce=0. Required: 2 busy cycles with d_bus=Z, then READ driving ~d_in. Toggle dce back to 1 during TURN: the count is not extended, and the state after TURN is WRITE.
6. Mid-operation reset. Assert rst_n=0 while in READ and while in TURN. Required: d_bus=Z and all outputs at reset values on that edge; after release, cs_n=1 keeps the block in IDLE.
